eth_speed_detect_mc: RTL and testbench

Multi-channel PHY link-speed detector for the 1G MAC family. It runs entirely in the gtx_clk domain. Each channel receives a prescaled RX-clock toggle bit, already synchronised into clk, and classifies link speed as 10M, 100M or 1000M. It adds hysteresis (N agreeing measurements before a change), link-loss detection and a change strobe, and drives speed/mii_select for multiple MAC instances.

---
 rtl/eth_speed_detect_mc.sv | 140 ++++++++++++++
 tb/tb_eth_speed_detect_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_speed_detect_mc.sv
// Multi-channel PHY link-speed detector: classifies each prescaled RX-clock toggle as
// 10M/100M/1000M with hysteresis, link-loss detection and a one-cycle change strobe.
module eth_speed_detect_mc #(
  parameter int CHANNELS       = 1,
  parameter int REF_WIDTH      = 7,
  parameter int EDGE_WIDTH     = 2,
  parameter int THRESH_100M    = 32,
  parameter int STABLE_COUNT   = 2,
  parameter int NOLINK_WINDOWS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   rx_toggle,
  output logic [2*CHANNELS-1:0] speed,
  output logic [CHANNELS-1:0]   mii_select,
  output logic [CHANNELS-1:0]   link_up,
  output logic [CHANNELS-1:0]   speed_change
);

  localparam int MATCH_W = $clog2(STABLE_COUNT + 1);
  localparam int EMPTY_W = $clog2(NOLINK_WINDOWS + 1);

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [REF_WIDTH-1:0] THRESH = REF_WIDTH'(THRESH_100M);
  localparam logic [MATCH_W-1:0]   STABLE = MATCH_W'(STABLE_COUNT);
  localparam logic [EMPTY_W-1:0]   NOLINK = EMPTY_W'(NOLINK_WINDOWS);

  function automatic logic [MATCH_W-1:0] sat_inc_match(input logic [MATCH_W-1:0] v);
    return (v >= STABLE) ? STABLE : v + 1'b1;
  endfunction

  function automatic logic [EMPTY_W-1:0] sat_inc_empty(input logic [EMPTY_W-1:0] v);
    return (v >= NOLINK) ? NOLINK : v + 1'b1;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  toggle_prev;
    logic                  edge_seen;
    logic [REF_WIDTH-1:0]  ref_cnt;
    logic [EDGE_WIDTH-1:0] edge_cnt;
    logic [EMPTY_W-1:0]    empty_cnt;
    logic [MATCH_W-1:0]    match_cnt;
    logic [1:0]            candidate;
    logic [1:0]            spd;
    logic                  mii;
    logic                  link;
    logic                  change_p1;
    logic                  change_p2;

    logic                  edge_det;
    logic                  ref_full;
    logic                  edge_full;
    logic                  empty_win;
    logic                  vld_p0;
    logic [1:0]            res_p0;
    logic [MATCH_W-1:0]    match_nxt;
    logic [EMPTY_W-1:0]    empty_nxt;
    logic                  link_loss;
    logic                  commit;

    // Stage 0: window measurement and classification of the closing window
    always_comb begin
      edge_det  = rx_toggle[c] ^ toggle_prev;
      ref_full  = &ref_cnt;
      edge_full = &edge_cnt;
      empty_win = ref_full && !edge_full && !edge_seen;
      vld_p0    = edge_full || (ref_full && edge_seen);
      res_p0    = SPD_10;
      if (edge_full) begin
        res_p0 = (ref_cnt >= THRESH) ? SPD_100 : SPD_1000;
      end
      match_nxt = (res_p0 == candidate) ? sat_inc_match(match_cnt) : MATCH_W'(1);
      empty_nxt = empty_cnt;
      if (vld_p0) begin
        empty_nxt = '0;
      end else if (empty_win) begin
        empty_nxt = sat_inc_empty(empty_cnt);
      end
      link_loss = empty_win && (empty_nxt == NOLINK);
      commit    = vld_p0 && (match_nxt == STABLE) && !link_loss;
    end

    // Stage 1: hysteresis, commit and link state; stage 2 delays the change strobe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        toggle_prev <= 1'b0;
        edge_seen   <= 1'b0;
        ref_cnt     <= '0;
        edge_cnt    <= '0;
        empty_cnt   <= '0;
        match_cnt   <= '0;
        candidate   <= SPD_1000;
        spd         <= SPD_1000;
        mii         <= 1'b0;
        link        <= 1'b0;
        change_p1   <= 1'b0;
        change_p2   <= 1'b0;
      end else begin
        toggle_prev <= rx_toggle[c];
        empty_cnt   <= empty_nxt;
        change_p1   <= 1'b0;
        change_p2   <= change_p1;
        if (edge_full || ref_full) begin
          ref_cnt   <= '0;
          edge_cnt  <= '0;
          edge_seen <= 1'b0;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
          if (edge_det) begin
            edge_cnt  <= edge_cnt + 1'b1;
            edge_seen <= 1'b1;
          end
        end
        if (link_loss) begin
          link      <= 1'b0;
          match_cnt <= '0;
          candidate <= SPD_1000;
        end else if (vld_p0) begin
          candidate <= res_p0;
          match_cnt <= match_nxt;
          if (commit) begin
            spd       <= res_p0;
            mii       <= (res_p0 != SPD_1000);
            link      <= 1'b1;
            change_p1 <= (res_p0 != spd) || !link;
          end
        end
      end
    end

    assign speed[2*c +: 2] = spd;
    assign mii_select[c]   = mii;
    assign link_up[c]      = link;
    assign speed_change[c] = change_p2;
  end

endmodule

// File: tb/tb_eth_speed_detect_mc.sv
// Scoreboard bench for eth_speed_detect_mc: a 2-channel STABLE_COUNT=2 instance and a
// 1-channel STABLE_COUNT=1 instance, driven by per-lane toggle generators.
module tb_eth_speed_detect_mc;

  typedef struct packed {
    logic       ld;
    logic [1:0] spd;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tog = 3'b000;

  logic [3:0] u0_speed;
  logic [1:0] u0_mii, u0_link, u0_chg;
  logic [1:0] u1_speed;
  logic       u1_mii, u1_link, u1_chg;

  eth_speed_detect_mc #(.CHANNELS(2), .STABLE_COUNT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_toggle(tog[1:0]),
    .speed(u0_speed), .mii_select(u0_mii), .link_up(u0_link), .speed_change(u0_chg)
  );

  eth_speed_detect_mc #(.CHANNELS(1), .STABLE_COUNT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_toggle(tog[2]),
    .speed(u1_speed), .mii_select(u1_mii), .link_up(u1_link), .speed_change(u1_chg)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  in_reset = 1'b1;
  ev_t q0[$], q1[$], q2[$];

  // lane 0 = u0 ch0, lane 1 = u0 ch1, lane 2 = u1 ch0
  int  half[3]  = '{0, 0, 0};
  bit  pat_go[3] = '{0, 0, 0};
  int  cnt[3]   = '{0, 0, 0};
  int  pidx[3]  = '{0, 0, 0};
  int  pat_gap[6] = '{4, 4, 4, 20, 20, 20};

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) begin
        if (pat_go[l]) begin
          if (pidx[l] < 24) begin
            cnt[l]++;
            if (cnt[l] >= pat_gap[pidx[l] % 6]) begin
              tog[l]  = ~tog[l];
              cnt[l]  = 0;
              pidx[l]++;
            end
          end
        end else begin
          pidx[l] = 0;
          if (half[l] == 0) cnt[l] = 0;
          else begin
            cnt[l]++;
            if (cnt[l] >= half[l]) begin
              tog[l] = ~tog[l];
              cnt[l] = 0;
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input int lane, input logic ld, input logic [1:0] s);
    ev_t e;
    e.ld  = ld;
    e.spd = s;
    case (lane)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic ev_check(input int lane, input logic ld, input logic [1:0] s,
                          input logic lk, input logic m);
    ev_t e;
    bit  have;
    have = 1'b0;
    e    = '0;
    case (lane)
      0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL unexpected_event lane%0d at %0t: got %s speed=%b link=%b mii=%b, required none",
               lane, $time, ld ? "linkdown" : "pulse", s, lk, m);
    end else if (e.ld != ld || e.spd != s || lk != !ld || m != (s != 2'b10)) begin
      n_bad++;
      $display("FAIL event lane%0d at %0t: got %s speed=%b link=%b mii=%b, required %s speed=%b link=%b mii=%b",
               lane, $time, ld ? "linkdown" : "pulse", s, lk, m,
               e.ld ? "linkdown" : "pulse", e.spd, !e.ld, (e.spd != 2'b10));
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  logic [2:0] sc_v, lk_v, mi_v, prev_lk;
  logic [5:0] sp_v;
  initial begin
    prev_lk = '0;
    forever begin
      @(negedge clk);
      sc_v = {u1_chg, u0_chg};
      lk_v = {u1_link, u0_link};
      mi_v = {u1_mii, u0_mii};
      sp_v = {u1_speed, u0_speed};
      if (!in_reset) begin
        for (int l = 0; l < 3; l++) begin
          if (sc_v[l]) ev_check(l, 1'b0, sp_v[2*l +: 2], lk_v[l], mi_v[l]);
          if (prev_lk[l] && !lk_v[l]) ev_check(l, 1'b1, sp_v[2*l +: 2], lk_v[l], mi_v[l]);
        end
      end
      prev_lk = lk_v;
    end
  end

  task automatic do_reset(input int cycles);
    in_reset = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_u0_speed"}, 32'(u0_speed), 32'hA);
    chk({tag, "_u0_mii"},   32'(u0_mii),   32'h0);
    chk({tag, "_u0_link"},  32'(u0_link),  32'h0);
    chk({tag, "_u0_chg"},   32'(u0_chg),   32'h0);
    chk({tag, "_u1_speed"}, 32'(u1_speed), 32'h2);
    chk({tag, "_u1_state"}, 32'({u1_mii, u1_link, u1_chg}), 32'h0);
    @(posedge clk);
    in_reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then alternating 1000M/100M windows on lane 0 (STABLE=2) and lane 2 (STABLE=1)
    do_reset(4);
    check_reset("rst0");
    for (int i = 0; i < 4; i++) begin
      push_ev(2, 1'b0, 2'b10);
      push_ev(2, 1'b0, 2'b01);
    end
    push_ev(2, 1'b1, 2'b01);
    pat_go[0] = 1'b1;
    pat_go[2] = 1'b1;
    run(1020);
    chk("alt_u0ch0_link", 32'(u0_link[0]), 32'h0);
    chk("alt_u0ch0_speed", 32'(u0_speed[1:0]), 32'h2);
    chk("alt_u1_speed_held", 32'(u1_speed), 32'h1);
    chk("alt_u1_link", 32'(u1_link), 32'h0);
    pat_go[0] = 1'b0;
    pat_go[2] = 1'b0;

    // 1000M on ch0, 100M on ch1
    do_reset(2);
    check_reset("rst1");
    push_ev(0, 1'b0, 2'b10);
    push_ev(1, 1'b0, 2'b01);
    half[0] = 4;
    half[1] = 20;
    run(1000);
    chk("g1_ch0_speed", 32'(u0_speed[1:0]), 32'h2);
    chk("g1_ch0_mii_link", 32'({u0_mii[0], u0_link[0]}), 32'h1);
    chk("m100_ch1_speed", 32'(u0_speed[3:2]), 32'h1);
    chk("m100_ch1_mii_link", 32'({u0_mii[1], u0_link[1]}), 32'h3);

    // ch0: 100M then back to 1000M
    push_ev(0, 1'b0, 2'b01);
    half[0] = 20;
    run(400);
    chk("to100_ch0_speed", 32'(u0_speed[1:0]), 32'h1);
    chk("to100_ch0_mii", 32'(u0_mii[0]), 32'h1);
    push_ev(0, 1'b0, 2'b10);
    half[0] = 4;
    run(300);
    chk("to1g_ch0_speed", 32'(u0_speed[1:0]), 32'h2);

    // ch0: 10M with interleaved empty windows
    push_ev(0, 1'b0, 2'b00);
    half[0] = 200;
    run(2000);
    chk("m10_ch0_speed", 32'(u0_speed[1:0]), 32'h0);
    chk("m10_ch0_mii_link", 32'({u0_mii[0], u0_link[0]}), 32'h3);

    // ch0: relock 1000M, lose link, relock with pulse at the same speed
    push_ev(0, 1'b0, 2'b10);
    half[0] = 4;
    run(400);
    push_ev(0, 1'b1, 2'b10);
    half[0] = 0;
    run(900);
    chk("loss_ch0_link", 32'(u0_link[0]), 32'h0);
    chk("loss_ch0_speed_mii", 32'({u0_speed[1:0], u0_mii[0]}), 32'h4);
    chk("loss_ch1_link", 32'(u0_link[1]), 32'h1);
    push_ev(0, 1'b0, 2'b10);
    half[0] = 4;
    run(300);
    chk("relock_ch0_link", 32'(u0_link[0]), 32'h1);

    // single-cycle reset mid-window, both channels relock independently
    do_reset(1);
    check_reset("rst2");
    push_ev(0, 1'b0, 2'b10);
    push_ev(1, 1'b0, 2'b01);
    run(500);
    chk("rl_ch0_speed", 32'(u0_speed[1:0]), 32'h2);
    chk("rl_ch1_speed", 32'(u0_speed[3:2]), 32'h1);
    chk("rl_links", 32'(u0_link), 32'h3);
    chk("rl_u1_link", 32'(u1_link), 32'h0);

    for (int i = 0; i < 2000 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
    while (q0.size() != 0) begin
      void'(q0.pop_front()); n_cmp++; n_bad++;
      $display("FAIL missing_event lane0: got none, required one more event");
    end
    while (q1.size() != 0) begin
      void'(q1.pop_front()); n_cmp++; n_bad++;
      $display("FAIL missing_event lane1: got none, required one more event");
    end
    while (q2.size() != 0) begin
      void'(q2.pop_front()); n_cmp++; n_bad++;
      $display("FAIL missing_event lane2: got none, required one more event");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
